// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS op/funct into ALU control, selects/extends/forwards operands, bubbles on load-use.
// Optional macro FORWARD_EN enables the EX/MEM and MEM/WB forwarding network; otherwise dependants wait for the writer.
module alu_issue_stage #(
  parameter int         DATA_W   = 32,
  parameter int         REG_AW   = 5,
  parameter logic [3:0] NOP_CTRL = 4'b1111
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Stall,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instr,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemDest,
  input  logic [DATA_W-1:0] ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbDest,
  input  logic [DATA_W-1:0] MemWbResult,
  output logic              OutValid,
  output logic [3:0]        AluCtrl,
  output logic [DATA_W-1:0] Input1,
  output logic [DATA_W-1:0] Input2,
  output logic [DATA_W-1:0] StoreData,
  output logic [REG_AW-1:0] Dest,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic              Illegal
);
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLL = 4'b1100;

  logic [5:0]  op, fn;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [15:0] imm;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  assign op   = Instr[31:26];
  assign rs_f = Instr[25:21];
  assign rt_f = Instr[20:16];
  assign rd_f = Instr[15:11];
  assign sh_f = Instr[10:6];
  assign fn   = Instr[5:0];
  assign imm  = Instr[15:0];
  assign rs_a = REG_AW'(rs_f);
  assign rt_a = REG_AW'(rt_f);
  assign rd_a = REG_AW'(rd_f);

  logic [DATA_W-1:0] rs_val, rt_val, imm_s, imm_z, sh_z;
  assign imm_s = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_z = {{(DATA_W-16){1'b0}}, imm};
  assign sh_z  = {{(DATA_W-5){1'b0}}, sh_f};

`ifdef FORWARD_EN
  // Younger producer (EX/MEM) wins; $0 is never forwarded.
  assign rs_val = (rs_f != 5'd0 && ExMemRegWrite && ExMemDest != '0 && ExMemDest == rs_a) ? ExMemResult :
                  (rs_f != 5'd0 && MemWbRegWrite && MemWbDest != '0 && MemWbDest == rs_a) ? MemWbResult : RsData;
  assign rt_val = (rt_f != 5'd0 && ExMemRegWrite && ExMemDest != '0 && ExMemDest == rt_a) ? ExMemResult :
                  (rt_f != 5'd0 && MemWbRegWrite && MemWbDest != '0 && MemWbDest == rt_a) ? MemWbResult : RtData;
`else
  assign rs_val = RsData;
  assign rt_val = RtData;
  logic unused_fwd;
  assign unused_fwd = ^{ExMemRegWrite, ExMemDest, ExMemResult, MemWbRegWrite, MemWbDest, MemWbResult};
`endif

  logic [3:0]        d_ctrl;
  logic [DATA_W-1:0] d_in1, d_in2, d_sd;
  logic [REG_AW-1:0] d_dest;
  logic              d_mr, d_mw, d_br, d_ill;

  always_comb begin
    d_ctrl = NOP_CTRL;
    d_in1  = '0;
    d_in2  = '0;
    d_sd   = '0;
    d_dest = '0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    case (op)
      6'h00: begin
        d_in1  = rs_val;
        d_in2  = rt_val;
        d_dest = rd_a;
        case (fn)
          6'h20, 6'h21: d_ctrl = C_ADD;
          6'h22, 6'h23: d_ctrl = C_SUB;
          6'h24:        d_ctrl = C_AND;
          6'h25:        d_ctrl = C_OR;
          6'h2A:        d_ctrl = C_SLT;
          6'h00: begin
            d_ctrl = C_SLL;
            d_in1  = rt_val;
            d_in2  = sh_z;
          end
          default: begin
            d_ill  = 1'b1;
            d_in1  = '0;
            d_in2  = '0;
            d_dest = '0;
          end
        endcase
      end
      6'h08, 6'h09: begin d_ctrl = C_ADD; d_in1 = rs_val; d_in2 = imm_s; d_dest = rt_a; end
      6'h0C:        begin d_ctrl = C_AND; d_in1 = rs_val; d_in2 = imm_z; d_dest = rt_a; end
      6'h0D:        begin d_ctrl = C_OR;  d_in1 = rs_val; d_in2 = imm_z; d_dest = rt_a; end
      6'h0A:        begin d_ctrl = C_SLT; d_in1 = rs_val; d_in2 = imm_s; d_dest = rt_a; end
      6'h23: begin d_ctrl = C_ADD; d_in1 = rs_val; d_in2 = imm_s; d_dest = rt_a; d_mr = 1'b1; end
      6'h2B: begin d_ctrl = C_ADD; d_in1 = rs_val; d_in2 = imm_s; d_sd = rt_val; d_mw = 1'b1; end
      6'h04: begin d_ctrl = C_SUB; d_in1 = rs_val; d_in2 = rt_val; d_br = 1'b1; end
      default: d_ill = 1'b1;
    endcase
  end

  logic rt_src, dep_match, hazard;
  assign rt_src    = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
  assign dep_match = (Dest != '0) && ((Dest == rs_a) || (rt_src && (Dest == rt_a)));

`ifdef FORWARD_EN
  assign hazard = InValid && OutValid && MemRead && dep_match;
`else
  // Without forwarding any dependant waits until the producer has written back.
  logic       dep;
  logic [1:0] wait_cnt;
  assign dep    = InValid && OutValid && RegWrite && dep_match;
  assign hazard = dep || (wait_cnt != 2'd0);

  always_ff @(posedge Clk) begin
    if (Reset)                  wait_cnt <= 2'd0;
    else if (!Stall) begin
      if (dep && !Flush)        wait_cnt <= 2'd2;
      else if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
    end
  end
`endif

  assign InReady = !Reset && !Stall && !hazard;

  logic kill, take;
  assign kill = Reset || Flush || (!Stall && (hazard || !InValid));
  assign take = !kill && !Stall;

  always_ff @(posedge Clk) begin
    if (kill) begin
      OutValid  <= 1'b0;
      AluCtrl   <= NOP_CTRL;
      Input1    <= '0;
      Input2    <= '0;
      StoreData <= '0;
      Dest      <= '0;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Branch    <= 1'b0;
      Illegal   <= 1'b0;
    end else if (take) begin
      OutValid  <= 1'b1;
      AluCtrl   <= d_ctrl;
      Input1    <= d_in1;
      Input2    <= d_in2;
      StoreData <= d_sd;
      Dest      <= d_dest;
      RegWrite  <= (d_dest != '0);
      MemRead   <= d_mr;
      MemWrite  <= d_mw;
      Branch    <= d_br;
      Illegal   <= d_ill;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases then randomized traffic against a decode-level reference model.
module tb_alu_issue_stage;
  logic        Clk, Reset, Flush, Stall, InValid, InReady;
  logic [31:0] Instr, RsData, RtData, ExMemResult, MemWbResult;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemDest, MemWbDest;
  logic        OutValid, RegWrite, MemRead, MemWrite, Branch, Illegal;
  logic [3:0]  AluCtrl;
  logic [31:0] Input1, Input2, StoreData;
  logic [4:0]  Dest;

  alu_issue_stage dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Stall(Stall), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .RsData(RsData), .RtData(RtData),
    .ExMemRegWrite(ExMemRegWrite), .ExMemDest(ExMemDest), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbDest(MemWbDest), .MemWbResult(MemWbResult),
    .OutValid(OutValid), .AluCtrl(AluCtrl), .Input1(Input1), .Input2(Input2), .StoreData(StoreData),
    .Dest(Dest), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        vld;
    logic [3:0]  ctrl;
    logic [31:0] in1, in2, sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, ill;
  } st_t;

  localparam st_t BUB = '{vld: 1'b0, ctrl: 4'hF, in1: 32'h0, in2: 32'h0, sd: 32'h0,
                          dest: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};

  st_t  q;
  int   blk;
  int   n_checks, n_fail;
  logic last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
`ifdef FORWARD_EN
    if (src != 0 && ExMemRegWrite && ExMemDest == src) return ExMemResult;
    if (src != 0 && MemWbRegWrite && MemWbDest == src) return MemWbResult;
`endif
    return rf;
  endfunction

  function automatic st_t decode(input logic [31:0] ins);
    st_t s;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    a  = fwd(rs, RsData);
    b  = fwd(rt, RtData);
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    s = BUB;
    s.vld = 1'b1;
    case (op)
      6'h00: begin
        s.dest = rd; s.in1 = a; s.in2 = b;
        case (fn)
          6'h20, 6'h21: s.ctrl = 4'b0010;
          6'h22, 6'h23: s.ctrl = 4'b0110;
          6'h24: s.ctrl = 4'b0000;
          6'h25: s.ctrl = 4'b0001;
          6'h2A: s.ctrl = 4'b0111;
          6'h00: begin s.ctrl = 4'b1100; s.in1 = b; s.in2 = {27'h0, sh}; end
          default: begin s.ill = 1'b1; s.dest = 0; end
        endcase
      end
      6'h08, 6'h09: begin s.ctrl = 4'b0010; s.in1 = a; s.in2 = se; s.dest = rt; end
      6'h0C: begin s.ctrl = 4'b0000; s.in1 = a; s.in2 = ze; s.dest = rt; end
      6'h0D: begin s.ctrl = 4'b0001; s.in1 = a; s.in2 = ze; s.dest = rt; end
      6'h0A: begin s.ctrl = 4'b0111; s.in1 = a; s.in2 = se; s.dest = rt; end
      6'h23: begin s.ctrl = 4'b0010; s.in1 = a; s.in2 = se; s.dest = rt; s.mr = 1'b1; end
      6'h2B: begin s.ctrl = 4'b0010; s.in1 = a; s.in2 = se; s.sd = b; s.mw = 1'b1; end
      6'h04: begin s.ctrl = 4'b0110; s.in1 = a; s.in2 = b; s.br = 1'b1; end
      default: s.ill = 1'b1;
    endcase
    s.rw = (s.dest != 0);
    return s;
  endfunction

  // Does the offered instruction read a register the instruction in the stage is about to produce?
  function automatic logic dep_hit();
    logic [5:0] op;
    logic       rt_src, match;
    op     = Instr[31:26];
    rt_src = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    match  = (q.dest != 0) && (q.dest == Instr[25:21] || (rt_src && q.dest == Instr[20:16]));
`ifdef FORWARD_EN
    return InValid && q.vld && q.mr && match;
`else
    return InValid && q.vld && q.rw && match;
`endif
  endfunction

  task automatic cyc();
    logic dep, haz;
    st_t  nx;
    #1;
    dep = dep_hit();
    haz = dep || (blk > 0);
    last_ready = InReady;
    check("in_ready", InReady, !Reset && !Stall && !haz);
    if (Reset)        nx = BUB;
    else if (Flush)   nx = BUB;
    else if (Stall)   nx = q;
    else if (haz)     nx = BUB;
    else if (InValid) nx = decode(Instr);
    else              nx = BUB;
`ifndef FORWARD_EN
    if (Reset) blk = 0;
    else if (!Stall) begin
      if (dep && !Flush) blk = 2;
      else if (blk > 0) blk--;
    end
`endif
    @(posedge Clk);
    #1;
    q = nx;
    check("out_valid", OutValid, q.vld);
    check("alu_ctrl", AluCtrl, q.ctrl);
    check("dest", Dest, q.dest);
    check("flags", {RegWrite, MemRead, MemWrite, Branch, Illegal}, {q.rw, q.mr, q.mw, q.br, q.ill});
    if (!q.vld || !q.ill) begin
      check("input1", Input1, q.in1);
      check("input2", Input2, q.in2);
    end
    if (!q.vld || q.mw) check("store_data", StoreData, q.sd);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    op = 6'h00;
    fn = 6'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2: case ($urandom_range(0, 8))
        0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23; 4: fn = 6'h24;
        5: fn = 6'h25; 6: fn = 6'h2A; 7: fn = 6'h00; default: ;
      endcase
      3: op = 6'h08; 4: op = 6'h09; 5: op = 6'h0C; 6: op = 6'h0D; 7: op = 6'h0A;
      8: op = 6'h23; 9: op = 6'h2B; 10: op = 6'h04;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), fn};
  endfunction

  initial begin
    int nb, exp_nb;
    n_checks = 0; n_fail = 0; blk = 0; q = BUB;
    Reset = 1; Flush = 0; Stall = 0; InValid = 0; Instr = 0; RsData = 0; RtData = 0;
    ExMemRegWrite = 0; ExMemDest = 0; ExMemResult = 0; MemWbRegWrite = 0; MemWbDest = 0; MemWbResult = 0;
    @(posedge Clk); #1;
    cyc(); cyc();
    check("rst_valid", OutValid, 0);
    check("rst_ctrl", AluCtrl, 4'hF);
    check("rst_dest", Dest, 0);
    check("rst_flags", {RegWrite, MemRead, MemWrite, Branch, Illegal}, 0);
    Reset = 0;

    InValid = 1; Instr = 32'h00221820; RsData = 5; RtData = 7; cyc();
    check("add_ctrl", AluCtrl, 4'b0010);
    check("add_in1", Input1, 5);
    check("add_in2", Input2, 7);
    check("add_dest", Dest, 3);
    check("add_rw", RegWrite, 1);

    Instr = 32'h2004FFFF; cyc();
    check("addi_in2", Input2, 32'hFFFFFFFF);
    Instr = 32'h3404FFFF; cyc();
    check("ori_in2", Input2, 32'h0000FFFF);
    check("ori_ctrl", AluCtrl, 4'b0001);
    Instr = 32'h00051100; RtData = 1; cyc();
    check("sll_ctrl", AluCtrl, 4'b1100);
    check("sll_in1", Input1, 1);
    check("sll_in2", Input2, 4);

    Instr = 32'h8C220000; cyc();
    check("lw_mr", MemRead, 1);
    Instr = 32'h00421820;
`ifdef FORWARD_EN
    exp_nb = 1;
`else
    exp_nb = 3;
`endif
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_ready) break;
      nb++;
    end
    check("lu_bubbles", nb, exp_nb);
    check("lu_issued", {OutValid, AluCtrl, Dest}, {1'b1, 4'b0010, 5'd3});

    ExMemRegWrite = 1; ExMemDest = 1; ExMemResult = 9;
    MemWbRegWrite = 1; MemWbDest = 1; MemWbResult = 8;
    RsData = 32'h64; RtData = 32'h65; Instr = 32'h00211820; cyc();
`ifdef FORWARD_EN
    check("fwd_in1", Input1, 9);
    check("fwd_in2", Input2, 9);
`else
    check("nofwd_in1", Input1, 32'h64);
    check("nofwd_in2", Input2, 32'h65);
`endif
    ExMemRegWrite = 0; MemWbRegWrite = 0;

    Flush = 1; Stall = 1; cyc();
    check("flush_stall_valid", OutValid, 0);
    Flush = 0; Stall = 0; Instr = 32'hFC000000; cyc();
    check("illegal_flag", Illegal, 1);
    check("illegal_ctrl", AluCtrl, 4'hF);
    check("illegal_valid", OutValid, 1);

    for (int i = 0; i < 3000; i++) begin
      Reset   = ($urandom_range(0, 99) == 0);
      Flush   = ($urandom_range(0, 7) == 0);
      Stall   = ($urandom_range(0, 5) == 0);
      InValid = ($urandom_range(0, 3) != 0);
      Instr   = rand_instr();
      RsData  = $urandom; RtData = $urandom;
      ExMemRegWrite = 1'($urandom); ExMemDest = 5'($urandom_range(0, 3)); ExMemResult = $urandom;
      MemWbRegWrite = 1'($urandom); MemWbDest = 5'($urandom_range(0, 3)); MemWbResult = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
